// File: rtl/instr_pkg.sv
// Shared opcodes, field positions and FSM states for the instr_exec block.
// Optional feature macro: INSTR_EXEC_MUL_EN enables opcode 7 (MUL).
package instr_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;

  localparam int unsigned OpMsb = 15;
  localparam int unsigned OpLsb = 12;
  localparam int unsigned RdMsb = 11;
  localparam int unsigned RdLsb = 8;
  localparam int unsigned RsMsb = 7;
  localparam int unsigned RsLsb = 4;
  localparam int unsigned RtMsb = 3;
  localparam int unsigned RtLsb = 0;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  // True for opcodes that commit their result to rd.
  function automatic logic op_writes(input logic [3:0] op);
    logic wr;
    wr = (op >= OP_ADD) && (op <= OP_LDI);
`ifdef INSTR_EXEC_MUL_EN
    if (op == OP_MUL) wr = 1'b1;
`endif
    return wr;
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational 4-bit datapath for instr_exec.
// Optional feature macro: INSTR_EXEC_MUL_EN adds the 4x4 multiplier.
module instr_alu
  import instr_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] imm_i,
  output logic [3:0] y_o,
  output logic       ovf_o
);

  logic [3:0] sum;
  logic [3:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

`ifdef INSTR_EXEC_MUL_EN
  logic [7:0] prod;
  assign prod = {4'h0, a_i} * {4'h0, b_i};
`endif

  always_comb begin
    y_o   = 4'h0;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o   = sum;
        ovf_o = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      OP_SUB: begin
        y_o   = diff;
        ovf_o = (a_i[3] != b_i[3]) && (diff[3] != a_i[3]);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_LDI: y_o = imm_i;
`ifdef INSTR_EXEC_MUL_EN
      OP_MUL: begin
        y_o   = prod[3:0];
        ovf_o = |prod[7:4];
      end
`endif
      default: begin
        y_o   = 4'h0;
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_exec.sv
// Multi-cycle 4-bit instruction executor: IDLE -> READ -> EXEC -> WB over a 16x4 register file.
// Optional feature macro: INSTR_EXEC_MUL_EN (opcode 7 = MUL, else illegal).
module instr_exec
  import instr_pkg::*;
#(
  parameter logic [3:0] REG_INIT = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        reg_write,
  output logic [3:0]  result,
  output logic        overflow,
  output logic        busy
);

  state_e      state_q;
  logic        reg_write_q;
  logic        armed_q;
  logic [15:0] instr_q;
  logic [3:0]  a_q, b_q, y_q;
  logic        ovf_q;
  logic [3:0]  result_q;
  logic        overflow_q;
  logic        busy_q;
  logic [3:0]  rf_q [16];

  logic       start;
  logic [3:0] alu_y;
  logic       alu_ovf;
  logic [3:0] op, rd, rs, rt;

  assign op = instr_q[OpMsb:OpLsb];
  assign rd = instr_q[RdMsb:RdLsb];
  assign rs = instr_q[RsMsb:RsLsb];
  assign rt = instr_q[RtMsb:RtLsb];

  // armed_q blocks a reg_write level that was already high when reset released.
  assign start = reg_write & ~reg_write_q & armed_q;

  instr_alu u_alu (
    .op_i  (op),
    .a_i   (a_q),
    .b_i   (b_q),
    .imm_i (rt),
    .y_o   (alu_y),
    .ovf_o (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      reg_write_q <= 1'b0;
      armed_q     <= 1'b0;
      instr_q     <= 16'h0000;
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      y_q         <= 4'h0;
      ovf_q       <= 1'b0;
      result_q    <= 4'h0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      rf_q[0]     <= 4'h0;
      for (int i = 1; i < 16; i++) rf_q[i] <= REG_INIT;
    end else begin
      reg_write_q <= reg_write;
      if (!reg_write) armed_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            instr_q <= instruction;
            busy_q  <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          // rf_q[0] is never written, so r0 always reads as zero.
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          state_q <= StExec;
        end
        StExec: begin
          y_q     <= alu_y;
          ovf_q   <= alu_ovf;
          state_q <= StWb;
        end
        StWb: begin
          if (op_writes(op) && (rd != 4'h0)) rf_q[rd] <= y_q;
          result_q   <= y_q;
          overflow_q <= ovf_q;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec: directed scenarios plus random instructions vs a behavioural model.
module tb_instr_exec;

  localparam logic [3:0] RI = 4'h2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        reg_write = 1'b0;
  logic [3:0]  result;
  logic        overflow;
  logic        busy;

  instr_exec #(.REG_INIT(RI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .reg_write   (reg_write),
    .result      (result),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ref_rf [16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Architectural model: what the instruction does to the register file and outputs.
  function automatic void model(input logic [15:0] ins, output logic [3:0] r, output logic o);
    int op, rd, a, b, imm, v, s;
    bit wr;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:8]);
    a   = ref_rf[ins[7:4]];
    b   = ref_rf[ins[3:0]];
    imm = int'(ins[3:0]);
    v = 0; o = 1'b0; wr = 1'b1;
    case (op)
      1: begin v = a + b; s = sgn(a) + sgn(b); o = (s > 7) || (s < -8); end
      2: begin v = a - b + 16; s = sgn(a) - sgn(b); o = (s > 7) || (s < -8); end
      3: v = a & b;
      4: v = a | b;
      5: v = a ^ b;
      6: v = imm;
`ifdef INSTR_EXEC_MUL_EN
      7: begin v = a * b; o = (v > 15); end
`endif
      default: begin v = 0; wr = 1'b0; end
    endcase
    v = v % 16;
    r = 4'(v);
    if (wr && rd != 0) ref_rf[rd] = v;
  endfunction

  task automatic model_reset();
    ref_rf[0] = 0;
    for (int i = 1; i < 16; i++) ref_rf[i] = int'(RI);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("busy_timeout", 1, 0);
  endtask

  // Raise reg_write for hold cycles, push the expected response, wait for completion.
  task automatic issue(input logic [15:0] ins, input int hold);
    exp_t e;
    logic [3:0] r;
    logic o;
    @(negedge clk);
    instruction = ins;
    reg_write = 1'b1;
    model(ins, r, o);
    e.res = r; e.ovf = o; e.due = cyc + 4;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    reg_write = 1'b0;
    instruction = $urandom;
    wait_idle();
  endtask

  // Monitor: a falling busy marks a completed instruction.
  int  hi_cnt = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      hi_cnt = 0;
    end else begin
      if (busy) hi_cnt++;
      else if (prev_busy) begin
        exp_t e;
        if (exp_q.size() == 0) check("unexpected_completion", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", int'(result), int'(e.res));
          check("overflow", int'(overflow), int'(e.ovf));
          check("latency", cyc, e.due);
          check("busy_cycles", hi_cnt, 3);
        end
        hi_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    model_reset();
    #1;
    check("rst_result", int'(result), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(16'h6105, 1);
    issue(16'h6203, 1);
    issue(16'h1312, 2);        // 5+3 -> 8 with signed overflow
    issue(16'h2421, 1);        // 3-5 -> E
    issue(16'h5541, 3);        // E^5 -> B

    // Second rising edge during EXEC must be ignored.
    begin
      exp_t e;
      logic [3:0] r;
      logic o;
      @(negedge clk);
      instruction = 16'h6A09;
      reg_write = 1'b1;
      model(16'h6A09, r, o);
      e.res = r; e.ovf = o; e.due = cyc + 4;
      exp_q.push_back(e);
      @(negedge clk);
      reg_write = 1'b0;
      @(negedge clk);
      instruction = 16'h6A0C;
      reg_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reg_write = 1'b0;
      wait_idle();
      issue(16'h1BA0, 1);      // r10 must hold 9, not C
    end

    issue(16'h6007, 1);        // LDI r0 -> result 7, write dropped
    issue(16'h1600, 1);        // r0+r0 -> 0
    issue(16'hF123, 1);        // illegal
    issue(16'h1C12, 1);        // r1+r2 unchanged
    issue(16'h7812, 1);        // MUL (or illegal)
    issue(16'h1D80, 1);        // read back r8

    // Reset during EXEC of ADD r7; reg_write held high across reset.
    @(negedge clk);
    instruction = 16'h1712;
    reg_write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_overflow", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_start_after_reset", int'(busy), 0);
    end
    reg_write = 1'b0;
    issue(16'h1970, 1);        // r7 must read REG_INIT

    for (int i = 0; i < 40; i++) issue(16'($urandom), int'($urandom_range(1, 3)));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
